ex_div: RTL and testbench

- Multi-cycle radix-2 restoring divider instantiated beside the execute stage, consuming the operands the ID/EX latch delivers for DIV/DIVU.
- The execute stage raises start_i and holds it, asserting its stall request until ready_o.
- The execute stage then writes result_o into HI/LO: HI = remainder, LO = quotient.
- annul_i cancels an in-flight division, used on pipeline flush or exception.

---
 rtl/ex_div.sv | 183 ++++++++++++++++++
 tb/tb_ex_div.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider for the execute stage
//
// Purpose:
//   Divides opdata1_i by opdata2_i (signed DIV or unsigned DIVU), one quotient
//   bit per clock, MSB first. The result is {remainder, quotient}, written by
//   the execute stage into HI/LO. A division takes DATA_W+1 clocks after the
//   start edge. A zero divisor takes one clock and gives an all-zero result.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i    dividend, sampled only when leaving IDLE
//   opdata2_i    divisor, sampled only when leaving IDLE
//   start_i      request, held high until the result has been consumed
//   annul_i      cancels an in-flight division (flush / exception)
//   result_o     {remainder, quotient}; zero unless ready_o is high
//   ready_o      result valid

module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  // The quotient register starts out holding |dividend|; each step shifts its
  // MSB into the partial remainder and a new quotient bit into its LSB.
  logic [DATA_W-1:0]   rem, rem_n;
  logic [DATA_W-1:0]   quo, quo_n;
  logic [DATA_W-1:0]   div_abs, div_abs_n;
  logic                sgn, sgn_n;
  logic                neg1, neg1_n;
  logic                neg2, neg2_n;
  logic [2*DATA_W-1:0] result_n;
  logic                ready_n;

  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W:0]     shifted, trial;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Magnitudes: two's-complement negate only for a signed divide of a
  // negative operand. 0x80000000 maps to itself, which is the correct
  // unsigned magnitude 2^31.
  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // The partial remainder is always below |divisor|, so after the shift it
  // fits in DATA_W+1 bits and the trial difference's MSB is its sign.
  assign shifted = {rem, quo[DATA_W-1]};
  assign trial   = shifted - {1'b0, div_abs};

  // Quotient is negative when the operand signs differ; the remainder takes
  // the sign of the dividend. Wrap-around (MIN / -1) falls out naturally.
  assign quo_fix = (sgn && (neg1 ^ neg2)) ? -quo : quo;
  assign rem_fix = (sgn && neg1) ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      div_abs  <= '0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      quo      <= quo_n;
      div_abs  <= div_abs_n;
      sgn      <= sgn_n;
      neg1     <= neg1_n;
      neg2     <= neg2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rem_n     = rem;
    quo_n     = quo;
    div_abs_n = div_abs;
    sgn_n     = sgn;
    neg1_n    = neg1;
    neg2_n    = neg2;
    result_n  = result_o;
    ready_n   = ready_o;

    case (state)
      S_IDLE: begin
        result_n = '0;
        ready_n  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = S_BYZERO;
          end else begin
            state_n   = S_ON;
            sgn_n     = signed_div_i;
            neg1_n    = opdata1_i[DATA_W-1];
            neg2_n    = opdata2_i[DATA_W-1];
            quo_n     = op1_abs;
            div_abs_n = op2_abs;
            rem_n     = '0;
            cnt_n     = '0;
          end
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_n = S_IDLE;
        end else begin
          state_n  = S_END;
          result_n = '0;
          ready_n  = 1'b1;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_n  = S_IDLE;
          ready_n  = 1'b0;
          result_n = '0;
        end else if (cnt != CNT_LAST) begin
          if (trial[DATA_W]) begin
            rem_n = shifted[DATA_W-1:0];
            quo_n = {quo[DATA_W-2:0], 1'b0};
          end else begin
            rem_n = trial[DATA_W-1:0];
            quo_n = {quo[DATA_W-2:0], 1'b1};
          end
          cnt_n = cnt + CNT_ONE;
        end else begin
          state_n  = S_END;
          result_n = {rem_fix, quo_fix};
          ready_n  = 1'b1;
        end
      end

      S_END: begin
        if (!start_i) begin
          state_n  = S_IDLE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end

      default: begin
        state_n  = S_IDLE;
        ready_n  = 1'b0;
        result_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard testbench for ex_div
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  ex_div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic cannot overflow for 32-bit operands,
  // and truncating division gives the remainder the dividend's sign.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      q   = sa / sb;
      r   = sa % sb;
      q32 = q[31:0];
      r32 = r[31:0];
    end else begin
      q32 = a / b;
      r32 = a % b;
    end
    return {r32, q32};
  endfunction

  // Drives the request and returns at the start edge E0.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
  endtask

  // Counts edges until ready_o; bounded so a stuck DUT still reaches the summary.
  task automatic wait_ready(input int lat, input string tag);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_o) break;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
  endtask

  task automatic finish_div(input int lat, input string tag);
    logic [63:0] e;
    wait_ready(lat, tag);
    e = exp_q.pop_front();
    check({tag, "_result"}, result_o, e);
    repeat (3) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_result"}, result_o, e);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'h0);
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] e, input int lat, input string tag);
    exp_q.push_back(e);
    launch(s, a, b);
    finish_div(lat, tag);
  endtask

  initial begin
    logic        seen;
    logic        s;
    logic [31:0] a, b;

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 33, "u100_7");
    run(1'b1, 32'hFFFFFFF9,  32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, "s_m7_2");
    run(1'b1, 32'h00000007,  32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, "s_7_m2");
    run(1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 33, "s_ovf");
    run(1'b0, 32'hFFFFFFFF,  32'h00000001, 64'h00000000_FFFFFFFF, 33, "u_max_1");
    run(1'b0, 32'hFFFFFFF9,  32'h00000002, 64'h00000001_7FFFFFFC, 33, "u_fff9_2");
    run(1'b0, 32'h00012345,  32'h00000000, 64'h0,                 1,  "u_byzero");
    run(1'b1, 32'h80000000,  32'h00000000, 64'h0,                 1,  "s_byzero");

    for (int i = 0; i < 6; i++) begin
      s = i[0];
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      run(s, a, b, model(s, a, b), (b == 32'h0) ? 1 : 33, $sformatf("rand%0d", i));
    end

    // Annul at the tenth ON edge; start stays high so a new divide follows.
    seen = 1'b0;
    launch(1'b0, 32'd5000, 32'd13);
    repeat (9) begin
      @(posedge clk);
      #1;
      seen |= ready_o;
    end
    @(negedge clk);
    annul_i   = 1'b1;
    opdata1_i = 32'd20;
    opdata2_i = 32'd3;
    @(posedge clk);
    #1;
    seen |= ready_o;
    check("annul_ready_seen", 64'(seen), 64'd0);
    check("annul_result", result_o, 64'h0);
    @(negedge clk);
    annul_i = 1'b0;
    exp_q.push_back(64'h00000002_00000006);
    @(posedge clk);
    finish_div(33, "annul_restart");

    // Reset in the middle of a division, with start still high at the reset edge.
    launch(1'b0, 32'd999999, 32'd77);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'h0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    seen    = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= ready_o;
    end
    check("midrst_idle_ready", 64'(seen), 64'd0);
    run(1'b1, 32'hFFFFFF9C, 32'd9, model(1'b1, 32'hFFFFFF9C, 32'd9), 33, "after_rst");

    // Operands and mode change after the start edge must not matter.
    exp_q.push_back(64'h00000006_0000008E);
    launch(1'b0, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    opdata1_i    = 32'hDEADBEEF;
    opdata2_i    = 32'h00000000;
    signed_div_i = 1'b1;
    finish_div(28, "opchange");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
